// File: rtl/four_port_switch_if.sv
// Port-level bundle for four_port_switch; per-port buses flattened, port k in slice k.
// SWITCH_STATS_EN adds the per-port packet/drop counter outputs.
interface four_port_switch_if #(
   parameter int DATA_W = 8
);
   logic [3:0]          valid_i;
   logic [4*DATA_W-1:0] data_i;
   logic [7:0]          dest_i;
   logic [3:0]          ready_o;
   logic [3:0]          valid_o;
   logic [4*DATA_W-1:0] data_o;
   logic [7:0]          src_o;
`ifdef SWITCH_STATS_EN
   logic [63:0]         pkt_cnt_o;
   logic [63:0]         drop_cnt_o;
`endif

`ifdef SWITCH_STATS_EN
   modport master (
      output valid_i, data_i, dest_i,
      input  ready_o, valid_o, data_o, src_o, pkt_cnt_o, drop_cnt_o
   );
   modport slave (
      input  valid_i, data_i, dest_i,
      output ready_o, valid_o, data_o, src_o, pkt_cnt_o, drop_cnt_o
   );
`else
   modport master (
      output valid_i, data_i, dest_i,
      input  ready_o, valid_o, data_o, src_o
   );
   modport slave (
      input  valid_i, data_i, dest_i,
      output ready_o, valid_o, data_o, src_o
   );
`endif
endinterface

// File: rtl/four_port_switch.sv
// 4-port single-beat packet switch: per-ingress FIFOs, per-egress round-robin arbiters, registered egress.
// Optional SWITCH_STATS_EN adds per-egress packet counters and per-ingress drop counters.
module four_port_switch #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   four_port_switch_if.slave  sw
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_W + 2;

   typedef logic [EW-1:0] entry_t;

   entry_t            mem_q    [4][FIFO_DEPTH];
   entry_t            mem_d    [4][FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q [4];
   logic [AW:0]       wr_ptr_d [4];
   logic [AW:0]       rd_ptr_q [4];
   logic [AW:0]       rd_ptr_d [4];
   logic [1:0]        rr_ptr_q [4];
   logic [1:0]        rr_ptr_d [4];
   logic [3:0]        valid_q;
   logic [3:0]        valid_d;
   logic [DATA_W-1:0] data_q   [4];
   logic [DATA_W-1:0] data_d   [4];
   logic [1:0]        src_q    [4];
   logic [1:0]        src_d    [4];

   logic [3:0]        full;
   logic [3:0]        empty;
   logic [3:0]        push;
   logic [3:0]        pop;
   entry_t            head     [4];
   logic [1:0]        cand;
   logic              found;

   // FIFO status: the extra pointer bit separates full from empty
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
         full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                    (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
         head[k]  = mem_q[k][rd_ptr_q[k][AW-1:0]];
         push[k]  = sw.valid_i[k] && !full[k];
      end
   end

   // Per-egress round-robin: first requester at or after rr_ptr wins
   always_comb begin
      pop     = '0;
      valid_d = '0;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned j = 0; j < 4; j++) begin
         rr_ptr_d[j] = rr_ptr_q[j];
         data_d[j]   = data_q[j];
         src_d[j]    = src_q[j];
         found       = 1'b0;
         for (int unsigned off = 0; off < 4; off++) begin
            cand = rr_ptr_q[j] + 2'(off);
            if (!found && !empty[cand] && (head[cand][EW-1 -: 2] == 2'(j))) begin
               found       = 1'b1;
               valid_d[j]  = 1'b1;
               data_d[j]   = head[cand][DATA_W-1:0];
               src_d[j]    = cand;
               rr_ptr_d[j] = cand + 2'd1;
               pop[cand]   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int unsigned k = 0; k < 4; k++) begin
         wr_ptr_d[k] = wr_ptr_q[k] + {{AW{1'b0}}, push[k]};
         rd_ptr_d[k] = rd_ptr_q[k] + {{AW{1'b0}}, pop[k]};
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k][AW-1:0]] = {sw.dest_i[2*k +: 2], sw.data_i[k*DATA_W +: DATA_W]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            rr_ptr_q[k] <= '0;
            data_q[k]   <= '0;
            src_q[k]    <= '0;
         end
         valid_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         src_q    <= src_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      sw.ready_o = ~full;
      sw.valid_o = valid_q;
      sw.data_o  = '0;
      sw.src_o   = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         sw.data_o[j*DATA_W +: DATA_W] = data_q[j];
         sw.src_o[2*j +: 2]            = src_q[j];
      end
   end

`ifdef SWITCH_STATS_EN
   logic [15:0] pkt_cnt_q  [4];
   logic [15:0] pkt_cnt_d  [4];
   logic [15:0] drop_cnt_q [4];
   logic [15:0] drop_cnt_d [4];

   // Counters wrap naturally at 16 bits
   always_comb begin
      for (int unsigned j = 0; j < 4; j++) begin
         pkt_cnt_d[j]  = pkt_cnt_q[j]  + {15'd0, valid_q[j]};
         drop_cnt_d[j] = drop_cnt_q[j] + {15'd0, sw.valid_i[j] & full[j]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < 4; j++) begin
            pkt_cnt_q[j]  <= '0;
            drop_cnt_q[j] <= '0;
         end
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      sw.pkt_cnt_o  = '0;
      sw.drop_cnt_o = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         sw.pkt_cnt_o[16*j +: 16]  = pkt_cnt_q[j];
         sw.drop_cnt_o[16*j +: 16] = drop_cnt_q[j];
      end
   end
`endif
endmodule

// File: tb/tb_four_port_switch.sv
// Directed + random bench for four_port_switch; a (src,dest)-keyed scoreboard checks every egress beat.
module tb_four_port_switch;
   logic clk;
   logic rst_n;

   four_port_switch_if #(.DATA_W(8)) sw_if ();

   four_port_switch #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb_q [16][$];
   int          out_cnt [16];
   int          out_total = 0;
   logic        mon_en = 1'b0;

   logic [3:0]  pend_v;
   logic [7:0]  pend_d   [4];
   logic [1:0]  pend_dst [4];
   logic [3:0]  acc;
   int          sent [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Egress monitor: every valid beat must match the oldest expected packet for its (src,dest)
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         for (int j = 0; j < 4; j++) begin
            if (sw_if.valid_o[j] === 1'b1) begin
               automatic int idx = int'(sw_if.src_o[2*j +: 2]) * 4 + j;
               out_cnt[idx]++;
               out_total++;
               chk($sformatf("egress%0d_expected_present", j), 32'(sb_q[idx].size() != 0), 32'd1);
               if (sb_q[idx].size() != 0) begin
                  automatic logic [7:0] exp_d = sb_q[idx].pop_front();
                  chk($sformatf("egress%0d_data", j), 32'(sw_if.data_o[8*j +: 8]), 32'(exp_d));
               end
            end
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         sb_q[i].delete();
         out_cnt[i] = 0;
      end
      out_total = 0;
      pend_v = '0;
      for (int k = 0; k < 4; k++) sent[k] = 0;
   endtask

   task automatic drive_idle();
      sw_if.valid_i = '0;
      sw_if.data_i  = '0;
      sw_if.dest_i  = '0;
   endtask

   // Drive pending packets at negedge, record which are accepted, advance to the next negedge
   task automatic cycle();
      for (int k = 0; k < 4; k++) begin
         sw_if.valid_i[k]       = pend_v[k];
         sw_if.data_i[8*k +: 8] = pend_d[k];
         sw_if.dest_i[2*k +: 2] = pend_dst[k];
      end
      #1;
      acc = pend_v & sw_if.ready_o;
      for (int k = 0; k < 4; k++) begin
         if (acc[k]) sb_q[k*4 + int'(pend_dst[k])].push_back(pend_d[k]);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      pend_v = '0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      logic done;
      rst_n  = 1'b0;
      pend_v = '0;
      for (int k = 0; k < 4; k++) begin
         pend_d[k] = '0;
         pend_dst[k] = '0;
      end
      drive_idle();
      clear_model();
      #1;
      chk("reset_valid_o", 32'(sw_if.valid_o), 32'h0);
      chk("reset_ready_o", 32'(sw_if.ready_o), 32'hF);
      chk("reset_data_o",  sw_if.data_o, 32'h0);
      chk("reset_src_o",   32'(sw_if.src_o), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Single packet: port 1 -> egress 2
      pend_v[1] = 1'b1; pend_d[1] = 8'hA5; pend_dst[1] = 2'd2;
      cycle();
      pend_v = '0;
      chk("single_not_yet", 32'(sw_if.valid_o), 32'h0);
      cycle();
      chk("single_valid_o", 32'(sw_if.valid_o), 32'h4);
      chk("single_data",    32'(sw_if.data_o[16 +: 8]), 32'hA5);
      chk("single_src",     32'(sw_if.src_o[4 +: 2]), 32'h1);
      cycle();
      chk("single_one_cycle", 32'(sw_if.valid_o), 32'h0);

      // Parallel non-conflicting: port k -> egress (k+1)%4
      for (int k = 0; k < 4; k++) begin
         pend_v[k] = 1'b1; pend_d[k] = 8'h30 + 8'(k); pend_dst[k] = 2'(k + 1);
      end
      cycle();
      pend_v = '0;
      cycle();
      chk("parallel_valid_o", 32'(sw_if.valid_o), 32'hF);
      chk("parallel_src_o",   32'(sw_if.src_o), 32'h93);
      chk("parallel_data_o",  sw_if.data_o, 32'h32313033);
      idle(2);

      // Contention: two bursts of all ports -> egress 3
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 4; k++) begin
            pend_v[k] = 1'b1; pend_d[k] = 8'hC0 + 8'(b*4 + k); pend_dst[k] = 2'd3;
         end
         cycle();
         pend_v = '0;
         for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("contend_b%0d_valid%0d", b, i), 32'(sw_if.valid_o), 32'h8);
            chk($sformatf("contend_b%0d_src%0d", b, i), 32'(sw_if.src_o[6 +: 2]), 32'(i));
         end
      end
      idle(2);

      // Full FIFO: port 0 sends 6 to egress 1 against streams from ports 1..3
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pend_v[k] = 1'b1; pend_d[k] = 8'(k*64); pend_dst[k] = 2'd1;
      end
      for (int c = 1; c <= 40 && sent[0] < 6; c++) begin
         cycle();
         if (c == 5) chk("full_ready0_low",  32'(sw_if.ready_o[0]), 32'h0);
         if (c == 6) chk("full_ready0_back", 32'(sw_if.ready_o[0]), 32'h1);
         if (c == 6) chk("full_push_dropped", 32'(acc[0]), 32'h0);
         for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
               sent[k]++;
               pend_d[k] = 8'(k*64 + sent[k]);
            end
         end
      end
      chk("full_port0_sent", 32'(sent[0]), 32'd6);
      idle(30);
      chk("full_port0_out", 32'(out_cnt[1]), 32'd6);
      for (int i = 0; i < 16; i++) chk($sformatf("full_sb_left_%0d", i), 32'(sb_q[i].size()), 32'd0);

      // Asynchronous reset mid-traffic
      for (int k = 0; k < 4; k++) begin
         pend_v[k] = 1'b1; pend_d[k] = 8'h50 + 8'(k); pend_dst[k] = 2'd0;
      end
      for (int i = 0; i < 8; i++) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_valid_o", 32'(sw_if.valid_o), 32'h0);
      chk("midreset_ready_o", 32'(sw_if.ready_o), 32'hF);
      chk("midreset_data_o",  sw_if.data_o, 32'h0);
      chk("midreset_src_o",   32'(sw_if.src_o), 32'h0);
      drive_idle();
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("postreset_valid_o", 32'(sw_if.valid_o), 32'h0);
      chk("postreset_ready_o", 32'(sw_if.ready_o), 32'hF);
      chk("postreset_no_output", 32'(out_total), 32'd0);

      // Random stress: 2000 packets per port
      do_reset();
      done = 1'b0;
      for (int c = 0; c < 30000 && !done; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (!pend_v[k] && sent[k] < 2000 && $urandom_range(3) != 0) begin
               pend_v[k] = 1'b1;
               pend_d[k] = 8'($urandom);
               pend_dst[k] = 2'($urandom_range(3));
            end
         end
         cycle();
         for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
               pend_v[k] = 1'b0;
               sent[k]++;
            end
         end
         done = (sent[0] == 2000) && (sent[1] == 2000) && (sent[2] == 2000) && (sent[3] == 2000);
      end
      chk("stress_all_sent", 32'(done), 32'h1);
      idle(40);
      chk("stress_out_total", 32'(out_total), 32'd8000);
      for (int i = 0; i < 16; i++) chk($sformatf("stress_sb_left_%0d", i), 32'(sb_q[i].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/four_port_switch.md
Name: four_port_switch

Overview:
- 4-port packet switch; each ingress port accepts single-beat packets (8-bit payload, 2-bit destination port number) into a per-port input FIFO.
- Per-egress round-robin arbiters forward FIFO heads to the addressed egress port, one packet per egress per cycle.
- Sits between the four port-level interfaces and the rest of the fabric.
- Per-port buses are flattened; port k occupies slice k.

Parameters:
- DATA_W, 8, payload width per packet.
- FIFO_DEPTH, 4, entries per ingress FIFO (power of 2, >=2).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  4  ingress packet valid, bit k = port k.
- data_i  input  4*DATA_W  ingress payload, port k at [k*DATA_W +: DATA_W].
- dest_i  input  8  ingress destination port number, port k at [2k+:2].
- ready_o  output  4  ingress port k can accept (FIFO k not full).
- valid_o  output  4  egress packet valid, bit k = egress port k.
- data_o  output  4*DATA_W  egress payload.
- src_o  output  8  egress source port number, egress k at [2k+:2].

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - All FIFOs empty, pointers 0.
  - ready_o=4'hF, valid_o=0, data_o=0, src_o=0.
  - All round-robin pointers = 0.
- Ingress acceptance:
  - Beat accepted on a rising edge when valid_i[k] && ready_o[k]; {dest, data} is pushed into FIFO k.
  - valid_i while ready_o=0 is ignored (dropped); the sender must hold it.
  - ready_o[k] = !full[k], combinational from FIFO state only.
- Arbitration, per egress j, each cycle:
  - Requesters are non-empty FIFOs whose head dest == j.
  - Round-robin search starts at rr_ptr[j]; the winner i is popped.
  - After a grant, rr_ptr[j] = i+1 mod 4. With no requesters, the pointer holds.
  - A FIFO head targets exactly one egress, so at most one pop per FIFO per cycle.
- Egress:
  - Registered. On the grant edge: valid_o[j]=1, data_o[j]=head data, src_o[j]=i.
  - With no grant: valid_o[j]=0; data_o and src_o hold their last value.
  - No egress backpressure.
- Latency:
  - A packet accepted at edge N into an empty FIFO, uncontended, appears on valid_o after edge N+1 (visible for exactly one cycle).
  - Throughput is 1 packet/cycle/egress.
- Loopback (dest == source port) is legal and treated normally.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Allowed, including when full (pop frees the slot, but ready_o reflects full, so no push is accepted that edge).
  - Count unchanged.
- Pointer wrap:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Full/empty are distinguished by an extra pointer bit.
- Ordering: packets from the same ingress to the same egress leave in arrival order (FIFO, head-of-line blocking accepted).
- Reset mid-operation: all in-flight and queued packets are discarded immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro SWITCH_STATS_EN.
- Defined:
  - Adds output pkt_cnt_o (4*16 bits); egress j count at [16j+:16].
  - The counter increments on every cycle valid_o[j] is asserted and wraps 16'hFFFF -> 0.
  - Also adds output drop_cnt_o (4*16) counting cycles where valid_i[k]=1 && ready_o[k]=0.
  - All counters reset to 0.
- Not defined: these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset check: rst_n=0 mid-traffic -> valid_o=0, ready_o=4'hF immediately, with no clock edge needed; FIFOs empty after release.
- Single packet: port 1 sends data 8'hA5, dest 2 -> one cycle later valid_o[2]=1, data_o[2]=8'hA5, src_o[2]=1; other valid_o bits remain 0.
- Contention: ports 0,1,2,3 all send to dest 3 in the same cycle:
  - Egress 3 outputs src 0,1,2,3 on four consecutive cycles.
  - A second identical burst outputs order 0,1,2,3 again (rr_ptr wrapped to 0 after src 3).
- Full FIFO: port 0 sends 6 back-to-back packets to dest 1 while port 1 continuously sends to dest 1:
  - ready_o[0] drops once 4 are queued and unserved.
  - All accepted packets exit in order; none are duplicated.
- Parallel non-conflicting: port k sends to dest (k+1)%4 simultaneously -> all four valid_o bits high on the same cycle with correct src_o.
- Random stress: 2000 random packets per port; a scoreboard keyed by (src, dest) matches every egress packet in FIFO order, with zero missing or extra after the drain.
